// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter
//   Registered, sequenced arbiter that shares one cacheline adaptor (256-bit line
//   port) between the instruction-side and data-side miss paths. One line
//   transaction runs at a time: the winner's command is latched into the ca_*
//   registers, the adaptor's completion is steered back to the winner, and a
//   RELEASE cycle gives the served requester time to drop its request.
//
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     defined   : after STARVE_LIMIT consecutive contested wins by the priority
//                 side, the next contested arbitration goes to the other side.
//     undefined : strict fixed priority per D_PRIORITY.
//
//   Ports
//     clk, rst                 system clock, synchronous active-high reset
//     i_read, i_addr           I-side line read request (held until i_resp)
//     i_data, i_resp           I-side read line and 1-cycle completion
//     d_read, d_write, d_addr  D-side line read / writeback request (held until d_resp)
//     d_wdata                  D-side writeback line
//     d_rdata, d_resp          D-side read line and 1-cycle completion
//     ca_read, ca_write        adaptor command (registered, one-hot or idle)
//     ca_addr, ca_wdata        adaptor address / write line (registered)
//     ca_rdata, ca_resp        adaptor read line and completion
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | no transaction; arbitrate and latch the winner's command
//   S_GRANT_I | I-side command on the adaptor, waiting for ca_resp
//   S_GRANT_D | D-side command on the adaptor, waiting for ca_resp
//   S_RELEASE | one dead cycle so the served requester can drop its request

module line_mem_arbiter #(
    parameter int D_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic [255:0] i_data,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         ca_read,
    output logic         ca_write,
    output logic [31:0]  ca_addr,
    output logic [255:0] ca_wdata,
    input  logic [255:0] ca_rdata,
    input  logic         ca_resp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("line_mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    state_t         state_q, state_d;
    logic           ca_read_q, ca_read_d;
    logic           ca_write_q, ca_write_d;
    logic [31:0]    ca_addr_q, ca_addr_d;
    logic [255:0]   ca_wdata_q, ca_wdata_d;

    logic           req_i, req_d, contested, prio_d, pick_d;

    assign req_i     = i_read;
    assign req_d     = d_read | d_write;
    assign contested = req_i & req_d;
    assign prio_d    = (D_PRIORITY != 0);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]  starve_q, starve_d;

    // Once the priority side has won LIMIT contested rounds in a row, the
    // loser gets the next contested round.
    assign pick_d = contested ? (prio_d ^ (starve_q == LIMIT)) : req_d;
`else
    assign pick_d = contested ? prio_d : req_d;
`endif

    // State register and latched adaptor command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ca_read_q  <= 1'b0;
            ca_write_q <= 1'b0;
            ca_addr_q  <= '0;
            ca_wdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ca_read_q  <= ca_read_d;
            ca_write_q <= ca_write_d;
            ca_addr_q  <= ca_addr_d;
            ca_wdata_q <= ca_wdata_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    // Next-state and next-command logic
    always_comb begin
        state_d    = state_q;
        ca_read_d  = ca_read_q;
        ca_write_d = ca_write_q;
        ca_addr_d  = ca_addr_q;
        ca_wdata_d = ca_wdata_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_d   = starve_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_i || req_d) begin
                    if (pick_d) begin
                        state_d    = S_GRANT_D;
                        ca_addr_d  = d_addr;
                        ca_wdata_d = d_wdata;
                        // A simultaneous read+write is illegal; the write wins.
                        ca_write_d = d_write;
                        ca_read_d  = ~d_write;
                    end else begin
                        state_d    = S_GRANT_I;
                        ca_addr_d  = i_addr;
                        ca_read_d  = 1'b1;
                        ca_write_d = 1'b0;
                    end
`ifdef ARB_STARVE_GUARD_EN
                    if (contested && (pick_d == prio_d)) begin
                        if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
`endif
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (ca_resp) begin
                    state_d    = S_RELEASE;
                    ca_read_d  = 1'b0;
                    ca_write_d = 1'b0;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: completions are a same-cycle pass-through of ca_resp to the
    // granted side, suppressed while rst is asserted.
    always_comb begin
        i_resp = 1'b0;
        d_resp = 1'b0;
        if (!rst && ca_resp) begin
            i_resp = (state_q == S_GRANT_I);
            d_resp = (state_q == S_GRANT_D);
        end
    end

    assign i_data   = ca_rdata;
    assign d_rdata  = ca_rdata;
    assign ca_read  = ca_read_q;
    assign ca_write = ca_write_q;
    assign ca_addr  = ca_addr_q;
    assign ca_wdata = ca_wdata_q;

`ifndef SYNTHESIS
    a_no_rw_together : assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));
    a_resp_only_granted : assert property (@(posedge clk) disable iff (rst)
        ca_resp |-> (state_q == S_GRANT_I || state_q == S_GRANT_D));
`endif

endmodule

// File: tb/tb_line_mem_arbiter.sv
module tb_line_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_data;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         ca_read;
    logic         ca_write;
    logic [31:0]  ca_addr;
    logic [255:0] ca_wdata;
    logic [255:0] ca_rdata;
    logic         ca_resp;

    always #5 clk = ~clk;

    line_mem_arbiter #(.D_PRIORITY(1), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .ca_read  (ca_read),
        .ca_write (ca_write),
        .ca_addr  (ca_addr),
        .ca_wdata (ca_wdata),
        .ca_rdata (ca_rdata),
        .ca_resp  (ca_resp)
    );

    typedef struct {
        logic         is_write;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } cmd_t;

    typedef struct {
        logic         side_d;
        logic         chk_data;
        logic [255:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 2;

    // Line returned by the adaptor model for a given address.
    function automatic logic [255:0] line_for(input logic [31:0] a);
        if (a == 32'h0000_0060) return {32{8'hA5}};
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [255:0] wd);
        cmd_t c;
        c.is_write = w; c.addr = a; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input logic sd, input logic cd, input logic [255:0] data);
        rsp_t r;
        r.side_d = sd; r.chk_data = cd; r.data = data;
        rsp_q.push_back(r);
    endtask

    // Adaptor model: answers a command after 'lat' cycles with a 1-cycle ca_resp.
    initial begin
        int cnt;
        cnt = 0;
        ca_resp  = 1'b0;
        ca_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                cnt = 0;
                ca_resp = 1'b0;
            end else if (ca_resp) begin
                ca_resp = 1'b0;
            end else if (ca_read || ca_write) begin
                cnt++;
                if (cnt >= lat) begin
                    ca_resp  = 1'b1;
                    ca_rdata = line_for(ca_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected commands/responses as the DUT presents them.
    logic         cmd_active = 1'b0;
    logic [289:0] cmd_hold;

    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            chk("resp_exclusive", {255'd0, i_resp & d_resp}, 256'd0);
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b required none", i_resp, d_resp);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("resp_side", {255'd0, d_resp}, {255'd0, e.side_d});
                if (e.chk_data) chk("resp_data", e.side_d ? d_rdata : i_data, e.data);
            end
        end
        if (rst) begin
            cmd_active <= 1'b0;
        end else begin
            if ((ca_read || ca_write) && !cmd_active) begin
                chk("cmd_onehot", {255'd0, ca_read & ca_write}, 256'd0);
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got rd=%0b wr=%0b addr=%0h required none", ca_read, ca_write, ca_addr);
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    chk("cmd_write", {255'd0, ca_write}, {255'd0, c.is_write});
                    chk("cmd_read", {255'd0, ca_read}, {255'd0, ~c.is_write});
                    chk("cmd_addr", {224'd0, ca_addr}, {224'd0, c.addr});
                    if (c.is_write) chk("cmd_wdata", ca_wdata, c.wdata);
                end
                cmd_hold <= {ca_read, ca_write, ca_addr, ca_wdata};
            end else if (ca_read || ca_write) begin
                chk("cmd_stable", {222'd0, ca_read, ca_write, ca_addr}, {222'd0, cmd_hold[289:256]});
            end
            cmd_active <= ca_read | ca_write;
        end
    end

    // Wait (bounded) for the given side's resp, then optionally drop its request
    // during RELEASE, and confirm the command has gone.
    task automatic wait_and_drop(input bit side_d, input bit keep);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = side_d ? d_resp : i_resp;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_resp_timeout: no resp after %0d cycles, required one", side_d ? "d" : "i", n);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (side_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
        @(negedge clk);
        chk("cmd_drop_after_resp", {254'd0, ca_read, ca_write}, 256'd0);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
        i_addr = 32'h40; d_addr = 32'h80; d_wdata = '0;

        // Reset with both requesting: outputs quiet, then D wins first.
        repeat (2) begin
            @(negedge clk);
            chk("rst_ctrl", {252'd0, ca_read, ca_write, i_resp, d_resp}, 256'd0);
            chk("rst_addr", {224'd0, ca_addr}, 256'd0);
            chk("rst_wdata", ca_wdata, 256'd0);
        end
        push_cmd(1'b0, 32'h80, '0); push_rsp(1'b1, 1'b1, line_for(32'h80));
        push_cmd(1'b0, 32'h40, '0); push_rsp(1'b0, 1'b1, line_for(32'h40));
        rst = 1'b0;
        fork
            wait_and_drop(1'b1, 1'b0);
            wait_and_drop(1'b0, 1'b0);
        join

        // Lone I read.
        settle();
        i_addr = 32'h60; i_read = 1'b1;
        push_cmd(1'b0, 32'h60, '0); push_rsp(1'b0, 1'b1, {32{8'hA5}});
        @(negedge clk);
        chk("lone_i_ca_read", {255'd0, ca_read}, 256'd1);
        chk("lone_i_ca_addr", {224'd0, ca_addr}, 256'h60);
        wait_and_drop(1'b0, 1'b0);

        // I read against D write: D first, then I.
        settle();
        i_addr = 32'hA0; i_read = 1'b1;
        d_addr = 32'h100; d_wdata = 256'h1; d_write = 1'b1;
        push_cmd(1'b1, 32'h100, 256'h1); push_rsp(1'b1, 1'b0, '0);
        push_cmd(1'b0, 32'hA0, '0);      push_rsp(1'b0, 1'b1, line_for(32'hA0));
        @(negedge clk);
        chk("contest_ca_write", {254'd0, ca_read, ca_write}, 256'd1);
        chk("contest_ca_wdata", ca_wdata, 256'h1);
        fork
            wait_and_drop(1'b1, 1'b0);
            wait_and_drop(1'b0, 1'b0);
        join

        // D abandons its read right after the grant; address also changes.
        settle();
        lat = 3;
        d_addr = 32'h200; d_read = 1'b1;
        push_cmd(1'b0, 32'h200, '0); push_rsp(1'b1, 1'b1, line_for(32'h200));
        @(negedge clk);
        d_read = 1'b0; d_addr = 32'h999;
        @(negedge clk);
        chk("abandon_held_read", {255'd0, ca_read}, 256'd1);
        chk("abandon_held_addr", {224'd0, ca_addr}, 256'h200);
        wait_and_drop(1'b1, 1'b0);

        // Reset during GRANT_D before ca_resp: command cleared, no d_resp.
        settle();
        d_addr = 32'h300; d_read = 1'b1;
        push_cmd(1'b0, 32'h300, '0);
        @(negedge clk);
        chk("rstmid_granted", {255'd0, ca_read}, 256'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        chk("rstmid_no_resp", {254'd0, i_resp, d_resp}, 256'd0);
        @(negedge clk);
        chk("rstmid_cleared", {254'd0, ca_read, ca_write}, 256'd0);
        chk("rstmid_addr", {224'd0, ca_addr}, 256'd0);
        rst = 1'b0;

        // Normal D read after the reset proves the FSM is back in IDLE.
        settle();
        lat = 2;
        d_addr = 32'h320; d_read = 1'b1;
        push_cmd(1'b0, 32'h320, '0); push_rsp(1'b1, 1'b1, line_for(32'h320));
        @(negedge clk);
        chk("post_rst_grant", {255'd0, ca_read}, 256'd1);
        wait_and_drop(1'b1, 1'b0);

        // Both held continuously: D issues five back-to-back reads.
        settle();
        i_addr = 32'h400; i_read = 1'b1;
        d_addr = 32'h500; d_read = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) begin
            push_cmd(1'b0, 32'h500 + 32'(k) * 32'h20, '0);
            push_rsp(1'b1, 1'b1, line_for(32'h500 + 32'(k) * 32'h20));
        end
        push_cmd(1'b0, 32'h400, '0); push_rsp(1'b0, 1'b1, line_for(32'h400));
        push_cmd(1'b0, 32'h580, '0); push_rsp(1'b1, 1'b1, line_for(32'h580));
`else
        for (int k = 0; k < 5; k++) begin
            push_cmd(1'b0, 32'h500 + 32'(k) * 32'h20, '0);
            push_rsp(1'b1, 1'b1, line_for(32'h500 + 32'(k) * 32'h20));
        end
        push_cmd(1'b0, 32'h400, '0); push_rsp(1'b0, 1'b1, line_for(32'h400));
`endif
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_and_drop(1'b1, k < 4);
                    if (k < 4) d_addr = 32'h500 + 32'(k + 1) * 32'h20;
                end
            end
            wait_and_drop(1'b0, 1'b0);
        join

        settle();
        chk("cmd_queue_drained", 256'(cmd_q.size()), 256'd0);
        chk("rsp_queue_drained", 256'(rsp_q.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
